// File: rtl/updown_counter_n.sv
// Parametrised up/down counter: programmable top value, clamped parallel load, wrap/saturate mode, cascadable TC.
// Q updates one edge after its controls, TC is combinational; UPDOWN_COUNTER_PRESCALE_EN adds an En prescaler.
module updown_counter_n #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int RESET_VAL = 2**WIDTH-1
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE  = 4
`endif
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Sat,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] QRST = WIDTH'(RESET_VAL);

    logic             at_top;
    logic             at_bot;
    logic             at_edge;
    logic             pre_last;
    logic             step;
    logic [WIDTH-1:0] q_next;

    assign at_top  = (Q == QMAX);
    assign at_bot  = (Q == '0);
    assign at_edge = Up ? at_top : at_bot;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);

    logic [PW-1:0] pre;

    assign pre_last = (pre == PLAST);

    // Load restarts the prescale spacing so the first step lands PRESCALE edges later.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pre <= '0;
        end else if (Load) begin
            pre <= '0;
        end else if (En) begin
            pre <= pre_last ? '0 : pre + PW'(1);
        end
    end
`else
    assign pre_last = 1'b1;
`endif

    assign step = En & ~Load & pre_last;
    assign TC   = step & at_edge;

    always_comb begin
        q_next = Q;
        if (Load) begin
            q_next = (D > QMAX) ? QMAX : D;
        end else if (step) begin
            if (Up) begin
                if (at_top) q_next = Sat ? QMAX : '0;
                else        q_next = Q + WIDTH'(1);
            end else begin
                if (at_bot) q_next = Sat ? '0 : QMAX;
                else        q_next = Q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Q <= QRST;
        end else begin
            Q <= q_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboarded bench: three counters (default, mod-10, mod-10 cascaded on the second's TC) vs an arithmetic model.
module tb_updown_counter_n;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, up_a, ld_a, sat_a;
    logic [3:0] d_a;
    logic       en_b, up_b, ld_b, sat_b;
    logic [3:0] d_b;
    logic       up_c, ld_c, sat_c;
    logic [3:0] d_c;
    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;

    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(4)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        , .PRESCALE(PS)
`endif
    ) ua (.CLK(clk), .Reset(rst), .En(en_a), .Up(up_a), .Load(ld_a), .D(d_a), .Sat(sat_a), .Q(q_a), .TC(tc_a));

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(9)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        , .PRESCALE(PS)
`endif
    ) ub (.CLK(clk), .Reset(rst), .En(en_b), .Up(up_b), .Load(ld_b), .D(d_b), .Sat(sat_b), .Q(q_b), .TC(tc_b));

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        , .PRESCALE(PS)
`endif
    ) uc (.CLK(clk), .Reset(rst), .En(tc_b), .Up(up_c), .Load(ld_c), .D(d_c), .Sat(sat_c), .Q(q_c), .TC(tc_c));

    typedef struct {
        int qa, qb, qc;
        int ta, tb, tc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    int mq[3];
    int mp[3];
    int mmax[3] = '{15, 9, 9};
    int mrst[3] = '{15, 9, 0};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = mrst[i];
            mp[i] = 0;
        end
    endfunction

    // Counter range is 0..max; a step off either end wraps modulo max+1 or is refused in saturate mode.
    function automatic void m_step(input int i, input bit en, input bit up, input bit ld, input int d, input bit sat);
        int n;
        if (ld) begin
            mq[i] = (d > mmax[i]) ? mmax[i] : d;
            mp[i] = 0;
        end else if (en) begin
            if (mp[i] == PS-1) begin
                mp[i] = 0;
                n = mq[i] + (up ? 1 : -1);
                if (n > mmax[i] || n < 0) n = sat ? mq[i] : ((n < 0) ? mmax[i] : 0);
                mq[i] = n;
            end else begin
                mp[i] = mp[i] + 1;
            end
        end
    endfunction

    function automatic int m_tc(input int i, input bit en, input bit up, input bit ld);
        return int'(en && !ld && mp[i] == PS-1 && (up ? mq[i] == mmax[i] : mq[i] == 0));
    endfunction

    // Issue one edge's worth of stimulus: advance the model, queue the post-edge expectation.
    task automatic tick();
        exp_t e;
        int   en_c;
        en_c = m_tc(1, en_b, up_b, ld_b);
        m_step(0, en_a, up_a, ld_a, d_a, sat_a);
        m_step(1, en_b, up_b, ld_b, d_b, sat_b);
        m_step(2, en_c != 0, up_c, ld_c, d_c, sat_c);
        e.qa = mq[0];
        e.qb = mq[1];
        e.qc = mq[2];
        e.ta = m_tc(0, en_a, up_a, ld_a);
        e.tb = m_tc(1, en_b, up_b, ld_b);
        e.tc = m_tc(2, e.tb != 0, up_c, ld_c);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    // Reset is raised away from any clock edge and its effect checked before the next edge.
    task automatic do_reset();
        int tb_exp;
        #2 rst = 1'b1;
        #1;
        m_reset();
        tb_exp = m_tc(1, en_b, up_b, ld_b);
        chk("rst_q_a", q_a, mq[0]);
        chk("rst_q_b", q_b, mq[1]);
        chk("rst_q_c", q_c, mq[2]);
        chk("rst_tc_a", tc_a, m_tc(0, en_a, up_a, ld_a));
        chk("rst_tc_b", tc_b, tb_exp);
        chk("rst_tc_c", tc_c, m_tc(2, tb_exp != 0, up_c, ld_c));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_all();
        en_a = 0; up_a = 0; ld_a = 0; sat_a = 0; d_a = 0;
        en_b = 0; up_b = 0; ld_b = 0; sat_b = 0; d_b = 0;
        up_c = 0; ld_c = 0; sat_c = 0; d_c = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("q_a", q_a, e.qa);
                chk("q_b", q_b, e.qb);
                chk("q_c", q_c, e.qc);
                chk("tc_a", tc_a, e.ta);
                chk("tc_b", tc_b, e.tb);
                chk("tc_c", tc_c, e.tc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        idle_all();
        #1;
        m_reset();
        chk("init_q_a", q_a, 15);
        chk("init_q_b", q_b, 9);
        chk("init_q_c", q_c, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Count up a bit from a loaded value, then reset mid-count.
        ld_a = 1; d_a = 4'd3;
        tick();
        ld_a = 0; en_a = 1; up_a = 1;
        repeat (4) tick();
        do_reset();

        // Default counter: 16 down steps from F, wrapping through 0.
        en_a = 1; up_a = 0; sat_a = 0;
        repeat (16 * PS) tick();

        // Mod-10 wrap upward from 0.
        en_a = 0;
        ld_b = 1; d_b = 4'd0;
        tick();
        ld_b = 0; en_b = 1; up_b = 1; sat_b = 0;
        repeat (12 * PS) tick();

        // Clamped load then saturate at top, then step down.
        ld_b = 1; d_b = 4'hC; sat_b = 1;
        tick();
        ld_b = 0; up_b = 1;
        repeat (3 * PS) tick();
        up_b = 0;
        repeat (2 * PS) tick();
        // Saturate at bottom.
        ld_b = 1; d_b = 4'd1;
        tick();
        ld_b = 0;
        repeat (3 * PS) tick();

        // Load wins over a simultaneous enable.
        en_b = 0; sat_b = 0;
        ld_a = 1; d_a = 4'd5; en_a = 0;
        tick();
        ld_a = 1; d_a = 4'd2; en_a = 1; up_a = 1;
        #1 chk("tc_during_load", tc_a, 0);
        tick();
        ld_a = 0; en_a = 0;
        repeat (5) tick();

        // Two-digit decimal cascade: 37 enabled edges from 00.
        ld_b = 1; d_b = 4'd0; ld_c = 1; d_c = 4'd0; up_c = 1; sat_c = 0;
        tick();
        ld_b = 0; ld_c = 0; en_b = 1; up_b = 1; sat_b = 0;
        repeat (37) tick();
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        chk("cascade_units", q_b, 7);
        chk("cascade_tens", q_c, 3);
`endif

        // Randomised traffic with occasional loads, direction flips and resets.
        for (int it = 0; it < 400; it++) begin
            en_a  = ($urandom_range(0, 3) != 0);
            up_a  = 1'($urandom_range(0, 1));
            ld_a  = ($urandom_range(0, 9) == 0);
            d_a   = 4'($urandom_range(0, 15));
            sat_a = 1'($urandom_range(0, 1));
            en_b  = ($urandom_range(0, 3) != 0);
            up_b  = 1'($urandom_range(0, 1));
            ld_b  = ($urandom_range(0, 9) == 0);
            d_b   = 4'($urandom_range(0, 15));
            sat_b = 1'($urandom_range(0, 1));
            up_c  = 1'($urandom_range(0, 1));
            ld_c  = ($urandom_range(0, 14) == 0);
            d_c   = 4'($urandom_range(0, 15));
            sat_c = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0) do_reset();
            tick();
        end

        idle_all();
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
